// File: rtl/secuencia_escritura_registros.sv
// Write sequencer: snapshots the selected clock/date/timer group and writes it register by register.
// Optional wr_done timeout compiled in with `define SEC_ESCRITURA_TIMEOUT_EN.
module secuencia_escritura_registros #(
  parameter logic [7:0] TIMEOUT_CICLOS = 8'd255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [1:0] funcion_conf,
  input  logic [7:0] seg_hora,
  input  logic [7:0] min_hora,
  input  logic [7:0] hora_hora,
  input  logic [7:0] dia_fecha,
  input  logic [7:0] mes_fecha,
  input  logic [7:0] jahr_fecha,
  input  logic [7:0] dia_semana,
  input  logic [7:0] seg_timer,
  input  logic [7:0] min_timer,
  input  logic [7:0] hora_timer,
  input  logic       wr_done,
  output logic       reg_wr,
  output logic [3:0] addr_mem_local,
  output logic [7:0] dato_escritura,
  output logic       ocupado,
  output logic       fin,
  output logic       error_wr
);

  typedef enum logic [2:0] {
    IDLE,
    CARGA,
    ESCRIBE,
    ESPERA,
    SIGUIENTE,
    FIN
  } estado_t;

  localparam logic [3:0] ADDR_REPOSO = 4'hF;

  estado_t    estado_q, estado_d;
  logic [1:0] grupo_q, grupo_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] snap_q [10];
  logic [7:0] snap_d [10];
  logic [3:0] primera, ultima;

`ifdef SEC_ESCRITURA_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       error_q, error_d;
`endif

  always_comb begin
    primera = 4'd0;
    ultima  = 4'd2;
    case (grupo_q)
      2'b10:   begin primera = 4'd3; ultima = 4'd6; end
      2'b11:   begin primera = 4'd7; ultima = 4'd9; end
      default: begin primera = 4'd0; ultima = 4'd2; end
    endcase
  end

  always_comb begin
    estado_d = estado_q;
    grupo_d  = grupo_q;
    addr_d   = addr_q;
    snap_d   = snap_q;
`ifdef SEC_ESCRITURA_TIMEOUT_EN
    cnt_d    = cnt_q;
    error_d  = 1'b0;
`endif
    case (estado_q)
      IDLE: begin
        if (iniciar && funcion_conf != 2'b00) begin
          grupo_d  = funcion_conf;
          estado_d = CARGA;
        end
      end
      CARGA: begin
        snap_d[0] = seg_hora;
        snap_d[1] = min_hora;
        snap_d[2] = hora_hora;
        snap_d[3] = dia_fecha;
        snap_d[4] = mes_fecha;
        snap_d[5] = jahr_fecha;
        snap_d[6] = dia_semana;
        snap_d[7] = seg_timer;
        snap_d[8] = min_timer;
        snap_d[9] = hora_timer;
        addr_d    = primera;
        estado_d  = ESCRIBE;
      end
      ESCRIBE: begin
`ifdef SEC_ESCRITURA_TIMEOUT_EN
        cnt_d = '0;
`endif
        estado_d = ESPERA;
      end
      ESPERA: begin
        if (wr_done) begin
          estado_d = SIGUIENTE;
        end
`ifdef SEC_ESCRITURA_TIMEOUT_EN
        // cnt_q counts completed ESPERA cycles; abort on the TIMEOUT_CICLOS-th one
        else if (cnt_q == TIMEOUT_CICLOS - 8'd1) begin
          addr_d   = ADDR_REPOSO;
          error_d  = 1'b1;
          estado_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      SIGUIENTE: begin
        if (addr_q == ultima) begin
          addr_d   = ADDR_REPOSO;
          estado_d = FIN;
        end else begin
          addr_d   = addr_q + 4'd1;
          estado_d = ESCRIBE;
        end
      end
      FIN: begin
        estado_d = IDLE;
      end
      default: begin
        addr_d   = ADDR_REPOSO;
        estado_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q <= IDLE;
      grupo_q  <= 2'b00;
      addr_q   <= ADDR_REPOSO;
      snap_q   <= '{default: '0};
    end else begin
      estado_q <= estado_d;
      grupo_q  <= grupo_d;
      addr_q   <= addr_d;
      snap_q   <= snap_d;
    end
  end

`ifdef SEC_ESCRITURA_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  assign error_wr = error_q;
`else
  assign error_wr = 1'b0;
`endif

  // Outputs decode straight from registered state, so reset clears them without a clock
  assign reg_wr         = (estado_q == ESCRIBE);
  assign ocupado        = (estado_q != IDLE);
  assign fin            = (estado_q == FIN);
  assign addr_mem_local = addr_q;
  assign dato_escritura = (addr_q <= 4'd9) ? snap_q[addr_q] : 8'h00;

endmodule

// File: tb/tb_secuencia_escritura_registros.sv
// Directed + randomized bench for secuencia_escritura_registros with a cycle-arithmetic reference model.
module tb_secuencia_escritura_registros;

  logic       clk;
  logic       reset;
  logic       iniciar;
  logic [1:0] funcion_conf;
  logic [7:0] tb_r [10];
  logic       wr_done;
  logic       reg_wr;
  logic [3:0] addr_mem_local;
  logic [7:0] dato_escritura;
  logic       ocupado;
  logic       fin;
  logic       error_wr;

  int unsigned errors = 0;
  int unsigned checks = 0;

  secuencia_escritura_registros #(.TIMEOUT_CICLOS(8'd255)) dut (
    .clk            (clk),
    .reset          (reset),
    .iniciar        (iniciar),
    .funcion_conf   (funcion_conf),
    .seg_hora       (tb_r[0]),
    .min_hora       (tb_r[1]),
    .hora_hora      (tb_r[2]),
    .dia_fecha      (tb_r[3]),
    .mes_fecha      (tb_r[4]),
    .jahr_fecha     (tb_r[5]),
    .dia_semana     (tb_r[6]),
    .seg_timer      (tb_r[7]),
    .min_timer      (tb_r[8]),
    .hora_timer     (tb_r[9]),
    .wr_done        (wr_done),
    .reg_wr         (reg_wr),
    .addr_mem_local (addr_mem_local),
    .dato_escritura (dato_escritura),
    .ocupado        (ocupado),
    .fin            (fin),
    .error_wr       (error_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reposo(input string tag);
    chk({tag, " reg_wr"},  32'(reg_wr), 32'd0);
    chk({tag, " addr"},    32'(addr_mem_local), 32'hF);
    chk({tag, " dato"},    32'(dato_escritura), 32'h00);
    chk({tag, " ocupado"}, 32'(ocupado), 32'd0);
    chk({tag, " fin"},     32'(fin), 32'd0);
    chk({tag, " error"},   32'(error_wr), 32'd0);
  endtask

  // Model: group g writes N registers from base; ESCRIBE of register k lands at cycle
  // 2 + k*(espera+2); fin at 2 + N*(espera+2). Cycle 1 is the CARGA cycle.
  task automatic secuencia(input logic [1:0] g, input int unsigned espera, input bit ruido,
                           input bit mezcla, input bit cambio_dia, input int unsigned corte);
    int unsigned base, n, p, fin_c, k, r;
    logic [7:0] snap [10];
    logic [3:0] a_exp;
    logic [7:0] d_exp;
    string      t;
    base  = (g == 2'd1) ? 0 : (g == 2'd2) ? 3 : 7;
    n     = (g == 2'd2) ? 4 : 3;
    p     = espera + 2;
    fin_c = 2 + n * p;
    @(negedge clk);
    funcion_conf = g;
    iniciar      = 1'b1;
    @(posedge clk);
    #1;
    iniciar = 1'b0;
    for (int unsigned c = 1; c <= fin_c + 3; c++) begin
      if (c == 1) snap = tb_r;
      k     = (c >= 2) ? (c - 2) / p : 0;
      r     = (c >= 2) ? (c - 2) % p : 0;
      a_exp = (c >= 2 && c < fin_c) ? 4'(base + k) : 4'hF;
      d_exp = (a_exp == 4'hF) ? 8'h00 : snap[a_exp];
      t     = $sformatf("g%0d c%0d", g, c);
      chk({t, " reg_wr"},  32'(reg_wr), 32'(c >= 2 && c < fin_c && r == 0));
      chk({t, " addr"},    32'(addr_mem_local), 32'(a_exp));
      chk({t, " dato"},    32'(dato_escritura), 32'(d_exp));
      chk({t, " ocupado"}, 32'(ocupado), 32'(c <= fin_c));
      chk({t, " fin"},     32'(fin), 32'(c == fin_c));
      chk({t, " error"},   32'(error_wr), 32'd0);
      if (corte != 0 && c == corte) begin
        reset = 1'b0;
        #1;
        chk_reposo({t, " reset async"});
        for (int unsigned j = 0; j < 3; j++) begin
          @(posedge clk);
          #1;
          chk_reposo({t, " en reset"});
        end
        @(negedge clk);
        reset   = 1'b1;
        wr_done = 1'b0;
        return;
      end
      wr_done = (c >= 2 && c < fin_c &&
                 (r == espera || (ruido && (r == 0 || r == espera + 1))));
      iniciar = (c == 4);
      if (mezcla && c >= 2) begin
        for (int i = 0; i < 10; i++) tb_r[i] = 8'($urandom);
        funcion_conf = 2'($urandom);
      end
      if (cambio_dia && c == 3) tb_r[3] = 8'h20;
      @(posedge clk);
      #1;
    end
    wr_done      = 1'b0;
    iniciar      = 1'b0;
    funcion_conf = 2'b00;
  endtask

  initial begin
    int unsigned n_err, n_fin;
    reset        = 1'b1;
    iniciar      = 1'b0;
    funcion_conf = 2'b00;
    wr_done      = 1'b0;
    for (int i = 0; i < 10; i++) tb_r[i] = 8'($urandom);
    #1 reset = 1'b0;
    #2;
    chk_reposo("reset inicial");
    #20;
    @(negedge clk);
    reset = 1'b1;

    // Hour write: (0,45) (1,30) (2,12), fin at cycle 11
    tb_r[0] = 8'h45; tb_r[1] = 8'h30; tb_r[2] = 8'h12;
    secuencia(2'd1, 1, 1'b0, 1'b0, 1'b0, 0);

    // Date snapshot: dia_fecha changes to 20 during first ESPERA, 15 must be written
    tb_r[3] = 8'h15;
    secuencia(2'd2, 1, 1'b0, 1'b0, 1'b1, 0);

    // Normal mode: iniciar ignored
    @(negedge clk);
    funcion_conf = 2'b00;
    iniciar      = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(posedge clk);
      #1;
      chk_reposo($sformatf("modo normal %0d", j));
    end

    // Timer with a second iniciar mid-sequence (cycle 4), then slow bus with stray wr_done
    secuencia(2'd3, 1, 1'b0, 1'b0, 1'b0, 0);
    secuencia(2'd3, 5, 1'b1, 1'b0, 1'b0, 0);

    // Reset in the first ESPERA of a date sequence, then a clean restart
    secuencia(2'd2, 1, 1'b0, 1'b0, 1'b0, 3);
    secuencia(2'd2, 1, 1'b0, 1'b0, 1'b0, 0);

    // Randomized sequences: random data, group, bus latency, input churn
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < 10; i++) tb_r[i] = 8'($urandom);
      secuencia(2'($urandom_range(1, 3)), $urandom_range(1, 6), 1'($urandom), 1'b1, 1'b0, 0);
    end

    // Bus never answers
    @(negedge clk);
    for (int i = 0; i < 10; i++) tb_r[i] = 8'($urandom);
    funcion_conf = 2'b11;
    iniciar      = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
    n_err = 0;
    n_fin = 0;
    for (int j = 0; j < 300; j++) begin
      @(posedge clk);
      #1;
      n_err += 32'(error_wr);
      n_fin += 32'(fin);
    end
    chk("sin respuesta fin", n_fin, 0);
`ifdef SEC_ESCRITURA_TIMEOUT_EN
    chk("timeout error_wr pulsos", n_err, 1);
    chk("timeout ocupado", 32'(ocupado), 32'd0);
    chk("timeout addr", 32'(addr_mem_local), 32'hF);
`else
    chk("sin timeout error_wr", n_err, 0);
    chk("sin timeout ocupado", 32'(ocupado), 32'd1);
    chk("sin timeout addr", 32'(addr_mem_local), 32'd7);
    chk("sin timeout dato", 32'(dato_escritura), 32'(tb_r[7]));
    chk("sin timeout reg_wr", 32'(reg_wr), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reposo("reset final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/secuencia_escritura_registros.md
# secuencia_escritura_registros

Write sequencer that transfers the locally held clock, date and timer registers to the RTC memory through the bus-cycle generator. It is the write-side counterpart of the read hold decoder. On a start pulse in a configuration mode, it snapshots the selected register group and walks its local addresses one by one. For each address it issues a single-cycle write request and waits for the bus cycle to complete. The read path is idle while this block is busy.

## Interface
- `TIMEOUT_CICLOS`, 255: maximum wait for `wr_done` per register; used only when the timeout feature is compiled in.
- `clk` input 1: system clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `iniciar` input 1: start pulse; sampled only in IDLE.
- `funcion_conf` input 2: 00 normal, 01 configure hour, 10 configure date, 11 configure timer.
- `seg_hora`, `min_hora`, `hora_hora` input 8 each: BCD time values.
- `dia_fecha`, `mes_fecha`, `jahr_fecha`, `dia_semana` input 8 each: BCD date and weekday values.
- `seg_timer`, `min_timer`, `hora_timer` input 8 each: BCD timer values.
- `wr_done` input 1: bus-cycle generator reports the current write as complete; high for at least one cycle.
- `reg_wr` output 1: write request, one-cycle pulse.
- `addr_mem_local` output 4: local address of the register being written.
- `dato_escritura` output 8: data for the current write.
- `ocupado` output 1: high from CARGA through FIN inclusive.
- `fin` output 1: one-cycle pulse when the whole sequence completes.
- `error_wr` output 1: one-cycle pulse on timeout abort; constant 0 when the timeout feature is compiled out.

## Operation
- Address map, identical to the read decoder: 0 seg_hora, 1 min_hora, 2 hora_hora, 3 dia_fecha, 4 mes_fecha, 5 jahr_fecha, 6 dia_semana, 7 seg_timer, 8 min_timer, 9 hora_timer.
- Group ranges: 01 writes 0..2; 10 writes 3..6; 11 writes 7..9.
- With `funcion_conf`=00, `iniciar` is ignored: no state change and no `fin`.
- FSM states are IDLE, CARGA, ESCRIBE, ESPERA, SIGUIENTE, FIN.
  - IDLE: on `iniciar` with `funcion_conf`≠00, go to CARGA.
  - CARGA: latch the group, snapshot all ten register inputs into internal copies, set `addr_mem_local` to the group's first address, go to ESCRIBE.
  - ESCRIBE: `reg_wr`=1, go to ESPERA.
  - ESPERA: hold until `wr_done`=1, then go to SIGUIENTE.
  - SIGUIENTE: if `addr_mem_local` equals the group's last address, go to FIN; otherwise increment the address and go to ESCRIBE.
  - FIN: `fin`=1, `addr_mem_local`=4'hF, go to IDLE.
- `dato_escritura` is the snapshot entry selected by `addr_mem_local`.
  - Input changes after CARGA do not affect the sequence.
  - `dato_escritura` is 0 whenever `addr_mem_local` is 4'hF.
- `addr_mem_local` and `dato_escritura` are stable from ESCRIBE until leaving ESPERA.
- The idle address 4'hF decodes to "all hold" on the read side.
- Changes on `funcion_conf` after CARGA are ignored until the block returns to IDLE.
- `iniciar` outside IDLE is ignored. It is not queued.
- `wr_done` outside ESPERA is ignored, including a `wr_done` in the same cycle as `reg_wr`.

## Timing
- Reset values: `reg_wr`=0, `addr_mem_local`=4'hF, `dato_escritura`=8'h00, `ocupado`=0, `fin`=0, `error_wr`=0, state IDLE, snapshot cleared.
- Let cycle 0 be the edge that samples `iniciar`. CARGA is cycle 1 and the first ESCRIBE is cycle 2.
- Each register costs 3 cycles (ESCRIBE, ESPERA, SIGUIENTE) when `wr_done` arrives in the first ESPERA cycle. Each extra wait cycle adds one cycle.
- `fin` is high in cycle 3N+2, where N is the group size:
  - hour group: cycle 11;
  - date group: cycle 14;
  - timer group: cycle 11.
- Asserting `reset` mid-sequence returns all outputs to their reset values asynchronously. No `fin` is produced and no `reg_wr` glitch occurs.

## Configuration
- Macro `SEC_ESCRITURA_TIMEOUT_EN`.
- Defined:
  - An 8-bit wait counter clears on entry to ESPERA and increments each cycle spent in ESPERA.
  - When it reaches `TIMEOUT_CICLOS` without `wr_done`, the block pulses `error_wr` for one cycle and goes directly to IDLE.
  - On abort: `addr_mem_local`=4'hF and no `fin`.
- Not defined: no counter exists, ESPERA waits indefinitely, and `error_wr` is tied to 0.

## Test plan
- Hour write: set `funcion_conf`=01, `seg_hora`=8'h45, `min_hora`=8'h30, `hora_hora`=8'h12, pulse `iniciar`; `wr_done` returns one cycle after each `reg_wr`.
  - Expect three `reg_wr` pulses with (addr, data) = (0,45), (1,30), (2,12).
  - Expect `fin` in cycle 11, then `addr_mem_local`=F.
- Date snapshot: set `funcion_conf`=10, start, then change `dia_fecha` from 8'h15 to 8'h20 during the first ESPERA.
  - Expect writes at addresses 3..6 and the written `dia_fecha` equal to 8'h15.
  - Expect `fin` in cycle 14.
- Normal mode and busy: pulse `iniciar` with `funcion_conf`=00.
  - Expect no `reg_wr`, `ocupado` remaining 0, and no `fin`.
  - Then start a timer sequence and pulse `iniciar` again mid-sequence: expect exactly three writes (addresses 7, 8, 9) and one `fin`.
- Slow bus: in timer mode, delay `wr_done` by 5 cycles per write.
  - Expect address and data stable throughout each wait.
  - Expect `fin` in cycle 11+3×4=23.
- Reset mid-sequence: assert `reset`=0 while in ESPERA during a date sequence.
  - Expect all outputs at reset values immediately and no `fin`.
  - After release, a new start works normally.
- Timeout, with the macro defined and `TIMEOUT_CICLOS`=4: never assert `wr_done`.
  - Expect `error_wr` pulsed once, return to IDLE, no `fin`, `addr_mem_local`=F.
  - Without the macro, the block stays in ESPERA with `ocupado`=1.
